// File: rtl/es_nios2_oci_pkg.sv
// Shared constants for the OCI trace packing path: code widths, word layout
// and trace code values.
package es_nios2_oci_pkg;

  localparam int CODE_W = 2;
  localparam int CODES  = 15;
  localparam int BUF_W  = CODE_W * CODES;
  localparam int CNT_W  = 4;
  localparam int OUT_W  = 36;

  // out_data layout: {count, ovf_mark, buffer}
  localparam int BUF_LSB  = 0;
  localparam int MARK_LSB = BUF_W;
  localparam int CNT_LSB  = BUF_W + 2;

  localparam logic [1:0] OVF_MARK = 2'b11;
  localparam logic [1:0] OVF_NONE = 2'b00;

  localparam logic [CODE_W-1:0] CODE_NT   = 2'b00;
  localparam logic [CODE_W-1:0] CODE_TK   = 2'b01;
  localparam logic [CODE_W-1:0] CODE_SYNC = 2'b10;
  localparam logic [CODE_W-1:0] CODE_EXC  = 2'b11;

  function automatic logic [OUT_W-1:0] pack_word(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       mark,
                                                 input logic [BUF_W-1:0] buffer);
    pack_word = {cnt, mark, buffer};
  endfunction

endpackage

// File: rtl/es_nios2_oci_dct_outreg.sv
// Single-entry valid/ready holding register for packed trace words; a new word
// may be loaded in the same cycle the current one is accepted.
module es_nios2_oci_dct_outreg
  import es_nios2_oci_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic             out_ready,
  output logic             slot_free,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
);

  logic             valid_r;
  logic [OUT_W-1:0] data_r;

  assign slot_free = ~valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Hold the word until accepted; data only changes on a load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      data_r  <= {OUT_W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/es_nios2_oci_dct_packer.sv
// Packs 2-bit instruction-trace codes into 15-code words for the trace FIFO,
// with flush, enable-edge flush, backpressure retry and drop accounting.
module es_nios2_oci_dct_packer
  import es_nios2_oci_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trace_en,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overflow
);

  logic [BUF_W-1:0]  buf_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DROP_W-1:0] drop_r;
  logic              overflow_r;
  logic              trace_en_d_r;
  logic              pend_full_r;
  logic              pend_flush_r;
  logic              ovf_pending_r;

  logic              accept_s, drop_s, fall_s;
  logic              full_trig_s, flush_trig_s, emit_s, emit_go_s, slot_free_s;
  logic [BUF_W-1:0]  new_buf_s;
  logic [CNT_W-1:0]  new_cnt_s;
  logic [1:0]        mark_s;
  logic [OUT_W-1:0]  word_s;

  assign dct_buffer = buf_r;
  assign dct_count  = cnt_r;
  assign drop_cnt   = drop_r;
  assign overflow   = overflow_r;

  // Next-state of the packing buffer and the emit decision for this cycle
  always_comb begin
    accept_s  = trace_en & code_valid & ~pend_full_r;
    drop_s    = trace_en & code_valid & pend_full_r;
    fall_s    = trace_en_d_r & ~trace_en;
    new_buf_s = buf_r;
    new_cnt_s = cnt_r;
    if (accept_s) begin
      new_buf_s = {buf_r[BUF_W-CODE_W-1:0], code};
      new_cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      new_buf_s = buf_r;
      new_cnt_s = cnt_r;
    end
    full_trig_s  = accept_s & (new_cnt_s == CNT_W'(CODES));
    flush_trig_s = (flush | fall_s | pend_flush_r) & (new_cnt_s != {CNT_W{1'b0}});
    // A held full word is always retried; its count is already CODES
    emit_s    = full_trig_s | flush_trig_s | pend_full_r;
    emit_go_s = emit_s & slot_free_s;
    if (ovf_pending_r | drop_s) begin
      mark_s = OVF_MARK;
    end else begin
      mark_s = OVF_NONE;
    end
    word_s = pack_word(new_cnt_s, mark_s, new_buf_s);
  end

  // Packing state, pending-emit flags and drop bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_r         <= {BUF_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      drop_r        <= {DROP_W{1'b0}};
      overflow_r    <= 1'b0;
      trace_en_d_r  <= 1'b0;
      pend_full_r   <= 1'b0;
      pend_flush_r  <= 1'b0;
      ovf_pending_r <= 1'b0;
    end else begin
      trace_en_d_r <= trace_en;
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_r != {DROP_W{1'b1}}) begin
          drop_r <= drop_r + {{(DROP_W-1){1'b0}}, 1'b1};
        end
      end
      if (emit_go_s) begin
        buf_r         <= {BUF_W{1'b0}};
        cnt_r         <= {CNT_W{1'b0}};
        pend_full_r   <= 1'b0;
        pend_flush_r  <= 1'b0;
        ovf_pending_r <= 1'b0;
      end else begin
        buf_r <= new_buf_s;
        cnt_r <= new_cnt_s;
        if (full_trig_s) begin
          pend_full_r <= 1'b1;
        end
        if (flush_trig_s) begin
          pend_flush_r <= 1'b1;
        end
        if (drop_s) begin
          ovf_pending_r <= 1'b1;
        end
      end
    end
  end

  es_nios2_oci_dct_outreg u_outreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (emit_go_s),
    .load_data (word_s),
    .out_ready (out_ready),
    .slot_free (slot_free_s),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_es_nios2_oci_dct_packer.sv
// Directed bench for the trace code packer: vector table plus multi-cycle
// sequences for backpressure, drops, enable edge and reset.
module tb_es_nios2_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        trace_en;
  logic        code_valid;
  logic [1:0]  code;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [35:0] out_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        en;
    logic        vld;
    logic [1:0]  code;
    logic        flush;
    logic        rdy;
    logic        exp_valid;
    logic [35:0] exp_data;
    logic [3:0]  exp_cnt;
    logic [29:0] exp_buf;
  } vec_t;

  vec_t vecs[13];

  es_nios2_oci_dct_packer #(.DROP_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trace_en   (trace_en),
    .code_valid (code_valid),
    .code       (code),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 36'h0,          4'd1, 30'h3};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 36'h0,          4'd2, 30'hE};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 36'h0,          4'd3, 30'h39};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 36'h3_0000_0039, 4'd0, 30'h0};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 36'h0,          4'd0, 30'h0};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 36'h0,          4'd0, 30'h0};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 36'h0,          4'd0, 30'h0};
    vecs[7]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 36'h0,          4'd1, 30'h0};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 36'h0,          4'd2, 30'h1};
    vecs[9]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 36'h0,          4'd3, 30'h6};
    vecs[10] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 36'h0,          4'd4, 30'h1B};
    vecs[11] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 36'h5_0000_006D, 4'd0, 30'h0};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 36'h0,          4'd0, 30'h0};

    reset_n = 1'b0; trace_en = 1'b0; code_valid = 1'b0; code = 2'b00;
    flush = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 36'h0);
    chk("rst_count", dct_count, 4'd0);
    chk("rst_drop", drop_cnt, 8'd0);
    chk("rst_ovf", overflow, 1'b0);
    reset_n = 1'b1;
    step();

    // Table: partial flush, flush at zero, code+flush at count 4
    for (int i = 0; i < 13; i++) begin
      trace_en = vecs[i].en; code_valid = vecs[i].vld; code = vecs[i].code;
      flush = vecs[i].flush; out_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_count", i), dct_count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_buf", i), dct_buffer, vecs[i].exp_buf);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
    end
    code_valid = 1'b0; flush = 1'b0;

    // Full word of 15 TK codes
    code_valid = 1'b1; code = 2'b01; out_ready = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("full_cnt14", dct_count, 4'd14);
    chk("full_notyet", out_valid, 1'b0);
    step();
    chk("full_valid", out_valid, 1'b1);
    chk("full_data", out_data, 36'hF_1555_5555);
    chk("full_cnt0", dct_count, 4'd0);

    // Hold that word while 14 more codes arrive, then 15th with acceptance
    out_ready = 1'b0; code = 2'b10;
    for (int i = 0; i < 14; i++) step();
    chk("hold_valid", out_valid, 1'b1);
    chk("hold_data", out_data, 36'hF_1555_5555);
    chk("hold_cnt", dct_count, 4'd14);
    out_ready = 1'b1;
    step();
    chk("pass_valid", out_valid, 1'b1);
    chk("pass_data", out_data, 36'hF_2AAA_AAAA);
    chk("pass_drop", drop_cnt, 8'd0);
    chk("pass_cnt", dct_count, 4'd0);
    code_valid = 1'b0;
    step();
    chk("pass_drain", out_valid, 1'b0);

    // Backpressure: hold a 2-code word, fill 15, drop 3
    out_ready = 1'b0; code_valid = 1'b1; code = 2'b01;
    step(); step();
    code_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("bp_w1_valid", out_valid, 1'b1);
    chk("bp_w1_data", out_data, 36'h2_0000_0005);
    code_valid = 1'b1; code = 2'b11;
    for (int i = 0; i < 18; i++) step();
    code_valid = 1'b0;
    chk("bp_cnt15", dct_count, 4'd15);
    chk("bp_drop3", drop_cnt, 8'd3);
    chk("bp_ovf", overflow, 1'b1);
    chk("bp_w1_stable", out_data, 36'h2_0000_0005);
    out_ready = 1'b1;
    step();
    chk("bp_w2_valid", out_valid, 1'b1);
    chk("bp_w2_data", out_data, 36'hF_FFFF_FFFF);
    chk("bp_w2_cnt", dct_count, 4'd0);
    step();
    chk("bp_w2_drain", out_valid, 1'b0);
    code_valid = 1'b1; code = 2'b00; flush = 1'b1;
    step();
    code_valid = 1'b0; flush = 1'b0;
    chk("bp_w3_valid", out_valid, 1'b1);
    chk("bp_w3_data", out_data, 36'h1_0000_0000);
    chk("bp_ovf_sticky", overflow, 1'b1);
    step();

    // Falling trace_en flushes the partial word
    code_valid = 1'b1; code = 2'b10;
    for (int i = 0; i < 7; i++) step();
    chk("en_cnt7", dct_count, 4'd7);
    chk("en_notyet", out_valid, 1'b0);
    trace_en = 1'b0; code_valid = 1'b0;
    step();
    chk("en_valid", out_valid, 1'b1);
    chk("en_data", out_data, 36'h7_0000_2AAA);
    chk("en_cnt0", dct_count, 4'd0);
    code_valid = 1'b1; code = 2'b11;
    for (int i = 0; i < 3; i++) step();
    chk("dis_cnt", dct_count, 4'd0);
    chk("dis_drop", drop_cnt, 8'd3);
    chk("dis_valid", out_valid, 1'b0);
    code_valid = 1'b0; trace_en = 1'b1;
    step();

    // Asynchronous reset at count 9 with a word held
    out_ready = 1'b0; code_valid = 1'b1; code = 2'b01; flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 9; i++) step();
    code_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_cnt", dct_count, 4'd9);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_data", out_data, 36'h0);
    chk("arst_cnt", dct_count, 4'd0);
    chk("arst_buf", dct_buffer, 30'h0);
    chk("arst_drop", drop_cnt, 8'd0);
    chk("arst_ovf", overflow, 1'b0);
    step();
    reset_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_valid%0d", i), out_valid, 1'b0);
      chk($sformatf("post_rst_cnt%0d", i), dct_count, 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
